// File: rtl/scan_mux_if.sv
// scan_mux_if: select/data bundle between a scan_mux and whatever drives it
interface scan_mux_if #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4
);
  localparam int SELW = $clog2(CHANNELS);
  logic en;
  logic mode;
  logic [SELW-1:0] sel;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [SELW-1:0] ch;
  logic valid;
  logic wrap;
  modport master (output en, mode, sel, din, input dout, ch, valid, wrap);
  modport slave (input en, mode, sel, din, output dout, ch, valid, wrap);
endinterface

// File: rtl/scan_mux.sv
// scan_mux: registered N-channel mux, manual select or round-robin scan with per-channel dwell
module scan_mux #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL = 2
) (
  input logic clk,
  input logic rst,
  scan_mux_if.slave bus
);
  localparam int SELW = $clog2(CHANNELS);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  typedef enum logic {MANUAL, SCAN} mode_t;
  mode_t st;
  logic [SELW-1:0] ptr, ptr_n, ch_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] dout_n, sel_word, ptr_word;
  logic valid_n, wrap_n, legal, last, ptr_last;
  function automatic logic [WIDTH-1:0] word(input logic [SELW-1:0] i, input logic [CHANNELS*WIDTH-1:0] d);
    word = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (i == SELW'(k)) word = d[k*WIDTH +: WIDTH];
  endfunction
  assign st = mode_t'(bus.mode);
  assign legal = 32'(bus.sel) < CHANNELS;
  assign last = cnt == CW'(DWELL - 1);
  assign ptr_last = ptr == SELW'(CHANNELS - 1);
  assign sel_word = word(bus.sel, bus.din);
  assign ptr_word = word(ptr, bus.din);
  always_comb begin
    dout_n = bus.dout;
    ch_n = bus.ch;
    valid_n = 1'b0;
    wrap_n = 1'b0;
    ptr_n = ptr;
    cnt_n = cnt;
    if (bus.en && st == MANUAL) begin
      dout_n = legal ? sel_word : '0;
      ch_n = bus.sel;
      valid_n = legal;
      ptr_n = legal ? bus.sel : ptr;
      cnt_n = legal ? '0 : cnt;
    end else if (bus.en) begin
      dout_n = ptr_word;
      ch_n = ptr;
      valid_n = 1'b1;
      wrap_n = last && ptr_last;
      cnt_n = last ? '0 : cnt + 1'b1;
      ptr_n = !last ? ptr : ptr_last ? '0 : ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dout <= '0;
      bus.ch <= '0;
      bus.valid <= 1'b0;
      bus.wrap <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      bus.dout <= dout_n;
      bus.ch <= ch_n;
      bus.valid <= valid_n;
      bus.wrap <= wrap_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed checks of a 4-channel and a 3-channel scan_mux
module tb_scan_mux;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  scan_mux_if #(.WIDTH(8), .CHANNELS(4)) a ();
  scan_mux_if #(.WIDTH(8), .CHANNELS(3)) b ();
  scan_mux #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  scan_mux #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_a(input string tag, input logic [7:0] d, input logic [1:0] c, input logic v, input logic w);
    chk({tag, ".dout"}, 32'(a.dout), 32'(d));
    chk({tag, ".ch"}, 32'(a.ch), 32'(c));
    chk({tag, ".valid"}, 32'(a.valid), 32'(v));
    chk({tag, ".wrap"}, 32'(a.wrap), 32'(w));
  endtask
  task automatic chk_b(input string tag, input logic [7:0] d, input logic [1:0] c, input logic v, input logic w);
    chk({tag, ".dout"}, 32'(b.dout), 32'(d));
    chk({tag, ".ch"}, 32'(b.ch), 32'(c));
    chk({tag, ".valid"}, 32'(b.valid), 32'(v));
    chk({tag, ".wrap"}, 32'(b.wrap), 32'(w));
  endtask
  initial begin
    logic [7:0] sd [9] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h11};
    logic [1:0] sc [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    a.din = 32'h44332211;
    b.din = 24'h332211;
    b.en = 1'b0;
    b.mode = 1'b0;
    b.sel = 2'd0;
    rst = 1'b1;
    a.en = 1'b1;
    a.mode = 1'b1;
    a.sel = 2'd0;
    cyc(); chk_a("rst0", 8'h00, 2'd0, 1'b0, 1'b0); chk_b("b_rst", 8'h00, 2'd0, 1'b0, 1'b0);
    cyc(); chk_a("rst1", 8'h00, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    a.mode = 1'b0;
    a.sel = 2'd2;
    cyc(); chk_a("man_sel2", 8'h33, 2'd2, 1'b1, 1'b0);
    a.sel = 2'd0;
    cyc(); chk_a("man_sel0", 8'h11, 2'd0, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(); chk_a("rst_scan", 8'h00, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    a.mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc(); chk_a($sformatf("scan%0d", i), sd[i], sc[i], 1'b1, i == 7);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc(); chk_a("gap_pre0", 8'h11, 2'd0, 1'b1, 1'b0);
    cyc(); chk_a("gap_pre1", 8'h11, 2'd0, 1'b1, 1'b0);
    cyc(); chk_a("gap_pre2", 8'h22, 2'd1, 1'b1, 1'b0);
    a.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk_a($sformatf("gap_hold%0d", i), 8'h22, 2'd1, 1'b0, 1'b0);
    end
    a.en = 1'b1;
    cyc(); chk_a("gap_post0", 8'h22, 2'd1, 1'b1, 1'b0);
    cyc(); chk_a("gap_post1", 8'h33, 2'd2, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(); chk_a("mid_rst", 8'h00, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(); chk_a("resume0", 8'h11, 2'd0, 1'b1, 1'b0);
    cyc(); chk_a("resume1", 8'h11, 2'd0, 1'b1, 1'b0);
    cyc(); chk_a("resume2", 8'h22, 2'd1, 1'b1, 1'b0);
    a.mode = 1'b0;
    a.sel = 2'd3;
    cyc(); chk_a("sw_man3", 8'h44, 2'd3, 1'b1, 1'b0);
    a.mode = 1'b1;
    cyc(); chk_a("sw_scan0", 8'h44, 2'd3, 1'b1, 1'b0);
    cyc(); chk_a("sw_scan1", 8'h44, 2'd3, 1'b1, 1'b1);
    cyc(); chk_a("sw_scan2", 8'h11, 2'd0, 1'b1, 1'b0);
    cyc(); chk_a("sw_scan3", 8'h11, 2'd0, 1'b1, 1'b0);
    b.en = 1'b1;
    b.sel = 2'd2;
    cyc(); chk_b("b_sel2", 8'h33, 2'd2, 1'b1, 1'b0);
    b.sel = 2'd3;
    cyc(); chk_b("b_sel3", 8'h00, 2'd3, 1'b0, 1'b0);
    b.mode = 1'b1;
    cyc(); chk_b("b_scan0", 8'h33, 2'd2, 1'b1, 1'b0);
    cyc(); chk_b("b_scan1", 8'h33, 2'd2, 1'b1, 1'b1);
    cyc(); chk_b("b_scan2", 8'h11, 2'd0, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
